pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the fetch stage: holds the PC register and selects the next PC from sequential increment, branch, jump, jump-register and exception targets under fixed priority. Adds stall hold, a one-entry pending-redirect buffer so redirects raised during a stall are not lost, and a registered redirect/flush indication for the IF/ID pipeline register.

## Interface
- WIDTH, 32, PC and target width in bits (≥ 8)
- RESET_PC, 32'h0000_0000, PC value loaded on reset (truncated to WIDTH)
- STEP, 4, sequential increment added to PC
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- stall_i  input  1  hold PC this cycle (hazard unit)
- branch_en_i / branch_pc_i  input  1 / WIDTH  taken branch and target
- jump_en_i / jump_pc_i  input  1 / WIDTH  j/jal and target
- jr_en_i / jr_pc_i  input  1 / WIDTH  jr/jalr and register target
- exc_en_i / exc_pc_i  input  1 / WIDTH  exception request and vector
- pc_o  output  WIDTH  current PC (registered)
- pc_plus_o  output  WIDTH  pc_o + STEP, combinational, modulo 2^WIDTH
- redirect_o  output  1  registered; high in the cycle pc_o first shows a non-sequential target
- pending_o  output  1  registered; pending-redirect buffer is valid
- misalign_o  output  1  registered misaligned-target flag (see Configuration)

## Operation
- Request priority, highest first: exc > jr > jump > branch; selected target = tgt. req = OR of the four enables.
- Pending buffer: pend_v (1 bit), pend_pc (WIDTH bits).
- Next-state rules, first match wins:
  1. rst_n = 0: pc_o ← RESET_PC; pend_v, redirect_o, misalign_o ← 0.
  2. exc_en_i = 1: pc_o ← exc_pc_i regardless of stall_i; pend_v ← 0; redirect_o ← 1.
  3. stall_i = 1 and req = 1: pc_o holds; pend_v ← 1, pend_pc ← tgt (newest request overwrites older pending); redirect_o ← 0.
  4. stall_i = 1 and req = 0: pc_o, pend_v and pend_pc hold; redirect_o ← 0.
  5. stall_i = 0 and req = 1: pc_o ← tgt; pend_v ← 0; redirect_o ← 1 (a live request beats pending).
  6. stall_i = 0 and pend_v = 1: pc_o ← pend_pc; pend_v ← 0; redirect_o ← 1.
  7. Otherwise: pc_o ← pc_o + STEP, wrapping modulo 2^WIDTH; redirect_o ← 0.
- Redirecting to a target equal to pc_o + STEP still asserts redirect_o.
- pending_o = pend_v.

## Timing
- Single-cycle redirect latency: a request sampled at edge N is visible on pc_o after edge N, with redirect_o high for that same cycle.
- A request raised during stall is applied at the first edge with stall_i = 0, delaying it by the stall length; redirect_o is high for one cycle only.
- An exception is never delayed by stall and clears any pending redirect.
- Reset mid-stall or with pending valid discards the pending entry; pc_o = RESET_PC in the cycle after the reset edge.
- Enables are level-sensitive per cycle; holding an enable for k unstalled cycles redirects k times.

## Configuration
- PC_ALIGN_CHECK_EN defined: on any redirect (rules 2, 5, 6), misalign_o ← 1 for one cycle if the loaded target has low log2(STEP) bits nonzero. The target is still loaded unmodified. Otherwise misalign_o ← 0. Reset clears it.
- PC_ALIGN_CHECK_EN undefined: misalign_o tied to 0; no check logic is built.

## Test plan
- Reset then free-run, WIDTH=32, RESET_PC=0x3000: pc_o goes 0x3000, 0x3004, 0x3008; redirect_o stays 0.
- branch_en_i and jump_en_i both set in the same cycle (branch 0x100, jump 0x200) -> pc_o = 0x200, redirect_o = 1 for one cycle, then 0x204.
- stall_i high for 3 cycles; branch to 0x400 pulsed in stall cycle 1, jr to 0x500 pulsed in cycle 2 -> pc_o holds, pending_o = 1; first unstalled cycle gives pc_o = 0x500, pending_o = 0.
- Pending branch 0x400 while stalled, then exc_en_i to vector 0x180 while still stalled -> pc_o = 0x180 immediately, pending_o = 0; after unstall PC runs sequentially from 0x184.
- rst_n low while pending_o = 1 -> next pc_o = RESET_PC, pending_o = 0. Also check pc_o = 0xFFFF_FFFC increments to 0x0000_0000.
- PC_ALIGN_CHECK_EN defined: jump to 0x202 -> pc_o = 0x202 and misalign_o = 1 for one cycle. Undefined: misalign_o = 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register: next PC is chosen from exc > jr > jump > branch, a pending redirect, or PC + STEP.
// Latency: one cycle from a sampled request to pc_o; a redirect raised in a stall is applied at the first unstalled edge.
// Backpressure: stall_i holds the PC and parks the newest request in a one-entry buffer; exceptions ignore stall_i.
// Optional: `define PC_ALIGN_CHECK_EN builds the misaligned-target flag; otherwise misalign_o is tied low.

module pc_sequencer #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STEP     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic [WIDTH-1:0] branch_pc_i,
  input  logic             jump_en_i,
  input  logic [WIDTH-1:0] jump_pc_i,
  input  logic             jr_en_i,
  input  logic [WIDTH-1:0] jr_pc_i,
  input  logic             exc_en_i,
  input  logic [WIDTH-1:0] exc_pc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             redirect_o,
  output logic             pending_o,
  output logic             misalign_o
);

  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  // Architectural state
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             redirect_q, redirect_d;

  // Selected request
  logic             req;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] pc_inc;

  // Sequential increment wraps naturally at 2^WIDTH
  assign pc_inc = pc_q + STEP_W;

  // Fixed-priority selection of the live redirect target
  always_comb begin
    req = exc_en_i | jr_en_i | jump_en_i | branch_en_i;
    tgt = branch_pc_i;
    if (exc_en_i) begin
      tgt = exc_pc_i;
    end else if (jr_en_i) begin
      tgt = jr_pc_i;
    end else if (jump_en_i) begin
      tgt = jump_pc_i;
    end else if (branch_en_i) begin
      tgt = branch_pc_i;
    end
  end

  // Next-state rules: exception, stalled capture, stalled hold, live redirect, pending replay, increment
  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    redirect_d = 1'b0;
    if (exc_en_i) begin
      // Exceptions bypass stall and drop whatever was parked
      pc_d       = exc_pc_i;
      pend_v_d   = 1'b0;
      redirect_d = 1'b1;
    end else if (stall_i) begin
      if (req) begin
        // Newest request overwrites an older parked one
        pend_v_d  = 1'b1;
        pend_pc_d = tgt;
      end
    end else if (req) begin
      // A live request supersedes the parked one
      pc_d       = tgt;
      pend_v_d   = 1'b0;
      redirect_d = 1'b1;
    end else if (pend_v_q) begin
      pc_d       = pend_pc_q;
      pend_v_d   = 1'b0;
      redirect_d = 1'b1;
    end else begin
      pc_d = pc_inc;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC_W;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= '0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      redirect_q <= redirect_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Low log2(STEP) bits of a loaded target must be zero; STEP of 1 never flags
  localparam int               ALIGN_BITS = (STEP > 1) ? $clog2(STEP) : 0;
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic misalign_q, misalign_d;

  // Flag only the cycle a redirect lands on a misaligned target; the target itself is not altered
  always_comb begin
    misalign_d = 1'b0;
    if (redirect_d && ((pc_d & ALIGN_MASK) != '0)) begin
      misalign_d = 1'b1;
    end
  end

  // Misalign flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o       = pc_q;
  assign pc_plus_o  = pc_inc;
  assign redirect_o = redirect_q;
  assign pending_o  = pend_v_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_PC = 0x3000, WIDTH = 32, STEP = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Expected values are hand-derived constants for each step.

module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        branch_en_i, jump_en_i, jr_en_i, exc_en_i;
  logic [31:0] branch_pc_i, jump_pc_i, jr_pc_i, exc_pc_i;
  logic [31:0] pc_o, pc_plus_o;
  logic        redirect_o, pending_o, misalign_o;

  int checks;
  int failures;

  pc_sequencer #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_3000),
    .STEP    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .branch_en_i(branch_en_i),
    .branch_pc_i(branch_pc_i),
    .jump_en_i  (jump_en_i),
    .jump_pc_i  (jump_pc_i),
    .jr_en_i    (jr_en_i),
    .jr_pc_i    (jr_pc_i),
    .exc_en_i   (exc_en_i),
    .exc_pc_i   (exc_pc_i),
    .pc_o       (pc_o),
    .pc_plus_o  (pc_plus_o),
    .redirect_o (redirect_o),
    .pending_o  (pending_o),
    .misalign_o (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    branch_en_i = 1'b0;
    jump_en_i   = 1'b0;
    jr_en_i     = 1'b0;
    exc_en_i    = 1'b0;
  endtask

  logic exp_mis;

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    stall_i     = 1'b0;
    branch_pc_i = '0;
    jump_pc_i   = '0;
    jr_pc_i     = '0;
    exc_pc_i    = '0;
    clr_req();

    // Reset state
    tick();
    tick();
    chk("rst_pc", pc_o, 32'h3000);
    chk("rst_pend", {31'b0, pending_o}, 32'h0);
    chk("rst_redir", {31'b0, redirect_o}, 32'h0);
    chk("rst_mis", {31'b0, misalign_o}, 32'h0);

    // Free run
    rst_n = 1'b1;
    tick();
    chk("run_pc1", pc_o, 32'h3004);
    chk("run_redir1", {31'b0, redirect_o}, 32'h0);
    tick();
    chk("run_pc2", pc_o, 32'h3008);
    chk("run_plus2", pc_plus_o, 32'h300C);

    // Branch and jump together: jump wins
    branch_en_i = 1'b1; branch_pc_i = 32'h100;
    jump_en_i   = 1'b1; jump_pc_i   = 32'h200;
    tick();
    clr_req();
    chk("prio_pc", pc_o, 32'h200);
    chk("prio_redir", {31'b0, redirect_o}, 32'h1);
    tick();
    chk("prio_next_pc", pc_o, 32'h204);
    chk("prio_next_redir", {31'b0, redirect_o}, 32'h0);

    // Stall three cycles with branch then jr parked
    stall_i = 1'b1;
    branch_en_i = 1'b1; branch_pc_i = 32'h400;
    tick();
    clr_req();
    chk("st1_pc", pc_o, 32'h204);
    chk("st1_pend", {31'b0, pending_o}, 32'h1);
    chk("st1_redir", {31'b0, redirect_o}, 32'h0);
    jr_en_i = 1'b1; jr_pc_i = 32'h500;
    tick();
    clr_req();
    chk("st2_pc", pc_o, 32'h204);
    tick();
    chk("st3_pc", pc_o, 32'h204);
    chk("st3_pend", {31'b0, pending_o}, 32'h1);
    stall_i = 1'b0;
    tick();
    chk("unst_pc", pc_o, 32'h500);
    chk("unst_pend", {31'b0, pending_o}, 32'h0);
    chk("unst_redir", {31'b0, redirect_o}, 32'h1);
    tick();
    chk("unst_next_pc", pc_o, 32'h504);
    chk("unst_next_redir", {31'b0, redirect_o}, 32'h0);

    // Exception during stall kills the pending branch
    stall_i = 1'b1;
    branch_en_i = 1'b1; branch_pc_i = 32'h400;
    tick();
    clr_req();
    chk("exs_pend_set", {31'b0, pending_o}, 32'h1);
    exc_en_i = 1'b1; exc_pc_i = 32'h180;
    tick();
    clr_req();
    chk("exc_pc", pc_o, 32'h180);
    chk("exc_pend", {31'b0, pending_o}, 32'h0);
    chk("exc_redir", {31'b0, redirect_o}, 32'h1);
    tick();
    chk("exc_hold_pc", pc_o, 32'h180);
    chk("exc_hold_redir", {31'b0, redirect_o}, 32'h0);
    stall_i = 1'b0;
    tick();
    chk("exc_seq_pc", pc_o, 32'h184);

    // Reset while pending is valid discards it
    stall_i = 1'b1;
    jump_en_i = 1'b1; jump_pc_i = 32'h600;
    tick();
    clr_req();
    chk("rpend_set", {31'b0, pending_o}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rpend_pc", pc_o, 32'h3000);
    chk("rpend_pend", {31'b0, pending_o}, 32'h0);
    rst_n = 1'b1;
    stall_i = 1'b0;
    tick();
    chk("rpend_after_pc", pc_o, 32'h3004);
    chk("rpend_after_redir", {31'b0, redirect_o}, 32'h0);

    // Wrap at the top of the address space
    jump_en_i = 1'b1; jump_pc_i = 32'hFFFF_FFFC;
    tick();
    clr_req();
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_plus", pc_plus_o, 32'h0);
    tick();
    chk("wrap_next_pc", pc_o, 32'h0);

    // Redirect to pc+STEP still flags a redirect
    branch_en_i = 1'b1; branch_pc_i = 32'h4;
    tick();
    clr_req();
    chk("seqtgt_pc", pc_o, 32'h4);
    chk("seqtgt_redir", {31'b0, redirect_o}, 32'h1);

    // Held jr enable redirects every unstalled cycle
    jr_en_i = 1'b1; jr_pc_i = 32'h40;
    tick();
    chk("hold1_pc", pc_o, 32'h40);
    tick();
    chk("hold2_pc", pc_o, 32'h40);
    chk("hold2_redir", {31'b0, redirect_o}, 32'h1);
    clr_req();

    // Exception beats jr while unstalled
    exc_en_i = 1'b1; exc_pc_i = 32'h80;
    jr_en_i  = 1'b1; jr_pc_i  = 32'h90;
    tick();
    clr_req();
    chk("excjr_pc", pc_o, 32'h80);

    // Misaligned jump target
`ifdef PC_ALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    jump_en_i = 1'b1; jump_pc_i = 32'h202;
    tick();
    clr_req();
    chk("mis_pc", pc_o, 32'h202);
    chk("mis_flag", {31'b0, misalign_o}, {31'b0, exp_mis});
    tick();
    chk("mis_next_pc", pc_o, 32'h206);
    chk("mis_next_flag", {31'b0, misalign_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
